// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the two-VC pop arbiter: FSM encodings, VC ids and
// the burst counter helper.
package vc_pop_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    localparam int BURST_W = 4;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] value);
        return (value == {BURST_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vc_pop_arbiter_grant.sv
// Combinational pop grant between VC0 (priority) and VC1, plus the next value
// of the consecutive-VC0 burst counter used for anti-starvation.
module vc_grant_logic
    import vc_pop_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 3
) (
    input  logic               active,
    input  logic               vc0_empty,
    input  logic               vc1_empty,
    input  logic               dst_almost_full,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               vc0_rd,
    output logic               vc1_rd,
    output logic [BURST_W-1:0] burst_nxt
);

    logic can_pop;
    logic force1;

    assign can_pop = active && !dst_almost_full;
    assign force1  = (burst_cnt == BURST_W'(MAX_BURST)) && !vc1_empty;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        vc0_rd    = 1'b0;
        vc1_rd    = 1'b0;
        burst_nxt = burst_cnt;

        if (can_pop) begin
            if (force1)          vc1_rd = 1'b1;
            else if (!vc0_empty) vc0_rd = 1'b1;
            else if (!vc1_empty) vc1_rd = 1'b1;
        end

        // The burst only counts VC0 wins while VC1 is actually waiting.
        if (vc1_rd || vc1_empty) burst_nxt = '0;
        else if (vc0_rd)         burst_nxt = sat_inc(burst_cnt);
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops at most one word per cycle from two per-VC source FIFOs into one
// destination FIFO, with weighted priority and a registered write side.
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int BW        = 6,
    parameter int MAX_BURST = 3
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          vc0_empty,
    input  logic [BW-1:0] vc0_data,
    output logic          vc0_rd,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc1_data,
    output logic          vc1_rd,
    input  logic          dst_almost_full,
    input  logic          dst_full,
    output logic          dst_wr,
    output logic [BW-1:0] dst_data,
    output logic          active_vc,
    output logic [7:0]    pop_cnt_vc0,
    output logic [7:0]    pop_cnt_vc1,
    output logic          error_output
);

    state_t             state;
    state_t             state_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_nxt;

    vc_grant_logic #(
        .MAX_BURST(MAX_BURST)
    ) u_grant (
        .active         (state == ST_ACTIVE),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .dst_almost_full(dst_almost_full),
        .burst_cnt      (burst_cnt),
        .vc0_rd         (vc0_rd),
        .vc1_rd         (vc1_rd),
        .burst_nxt      (burst_nxt)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_L) begin
            state     <= ST_INIT;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE:   if (!dst_almost_full && (!vc0_empty || !vc1_empty)) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (dst_almost_full || (vc0_empty && vc1_empty))    state_nxt = ST_IDLE;
            default:   state_nxt = ST_INIT;
        endcase
    end

    // The popped word lands in the destination one cycle after its rd strobe.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dst_wr    <= 1'b0;
            dst_data  <= '0;
            active_vc <= VC0;
        end else begin
            dst_wr <= vc0_rd || vc1_rd;
            if (vc1_rd) begin
                dst_data  <= vc1_data;
                active_vc <= VC1;
            end else if (vc0_rd) begin
                dst_data  <= vc0_data;
                active_vc <= VC0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_cnt_vc0 <= '0;
            pop_cnt_vc1 <= '0;
        end else begin
            if (vc0_rd) pop_cnt_vc0 <= pop_cnt_vc0 + 8'd1;
            if (vc1_rd) pop_cnt_vc1 <= pop_cnt_vc1 + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)               error_output <= 1'b0;
        else if (dst_wr && dst_full) error_output <= 1'b1;
    end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Randomized bench for vc_pop_arbiter: queue-based source FIFOs and a
// rule-level reference model predict every strobe and registered output.
module tb_vc_pop_arbiter;

    localparam int BW        = 6;
    localparam int MAX_BURST = 3;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          vc0_empty, vc1_empty;
    logic [BW-1:0] vc0_data, vc1_data;
    logic          vc0_rd, vc1_rd;
    logic          dst_almost_full, dst_full;
    logic          dst_wr;
    logic [BW-1:0] dst_data;
    logic          active_vc;
    logic [7:0]    pop_cnt_vc0, pop_cnt_vc1;
    logic          error_output;

    vc_pop_arbiter #(.BW(BW), .MAX_BURST(MAX_BURST)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .vc0_empty      (vc0_empty),
        .vc0_data       (vc0_data),
        .vc0_rd         (vc0_rd),
        .vc1_empty      (vc1_empty),
        .vc1_data       (vc1_data),
        .vc1_rd         (vc1_rd),
        .dst_almost_full(dst_almost_full),
        .dst_full       (dst_full),
        .dst_wr         (dst_wr),
        .dst_data       (dst_data),
        .active_vc      (active_vc),
        .pop_cnt_vc0    (pop_cnt_vc0),
        .pop_cnt_vc1    (pop_cnt_vc1),
        .error_output   (error_output)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // Reference model: phase after reset, consecutive VC0 wins, expected outputs.
    int            m_phase;   // 0 = settling after reset, 1 = waiting, 2 = draining
    int            m_streak;
    logic          m_wr, m_vc, m_err;
    logic [BW-1:0] m_data;
    logic [7:0]    m_cnt0, m_cnt1;

    logic [26:0] obs_vec, exp_vec;

    function automatic logic [26:0] out_vec();
        return {dst_wr, dst_data, active_vc, pop_cnt_vc0, pop_cnt_vc1, error_output, 2'b00};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_streak = 0;
        m_wr = 1'b0; m_vc = 1'b0; m_err = 1'b0; m_data = '0;
        m_cnt0 = '0; m_cnt1 = '0;
    endtask

    // One clock cycle: drive sources from the queues, sample the rd strobes
    // before the edge and the registered outputs after it.
    task automatic step();
        logic e0, e1, p0, p1, af;
        logic [1:0] rd_seen;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        af = dst_almost_full;
        vc0_empty = e0;
        vc1_empty = e1;
        vc0_data  = e0 ? BW'($urandom) : q0[0];
        vc1_data  = e1 ? BW'($urandom) : q1[0];
        #1;
        p0 = 1'b0; p1 = 1'b0;
        if (m_phase == 2 && !af) begin
            if (!e1 && m_streak == MAX_BURST) p1 = 1'b1;
            else if (!e0)                     p0 = 1'b1;
            else if (!e1)                     p1 = 1'b1;
        end
        rd_seen = {vc0_rd, vc1_rd};
        @(posedge clk);
        #1;
        if (m_wr && dst_full) m_err = 1'b1;
        m_wr = p0 || p1;
        if (p0) begin m_data = q0.pop_front(); m_vc = 1'b0; m_cnt0 = m_cnt0 + 8'd1; end
        if (p1) begin m_data = q1.pop_front(); m_vc = 1'b1; m_cnt1 = m_cnt1 + 8'd1; end
        if (p1 || e1)  m_streak = 0;
        else if (p0)   m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        if (m_phase == 0)                               m_phase = 1;
        else if (m_phase == 1 && !af && !(e0 && e1))    m_phase = 2;
        else if (m_phase == 2 && (af || (e0 && e1)))    m_phase = 1;
        obs_vec = out_vec() | {25'd0, rd_seen};
        exp_vec = {m_wr, m_data, m_vc, m_cnt0, m_cnt1, m_err, p0, p1};
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 reset_L = 1'b0;
        #1;
        n_checks++;
        if ({out_vec(), vc0_rd, vc1_rd} !== 29'd0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected 0", {out_vec(), vc0_rd, vc1_rd});
        end
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
        dst_almost_full = 1'b0; dst_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_vec(), vc0_rd, vc1_rd} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {out_vec(), vc0_rd, vc1_rd});
        end
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    task automatic test_priority();
        logic vcs[$];
        logic exp_pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) q0.push_back(BW'($urandom));
        for (int i = 0; i < 5; i++)  q1.push_back(BW'($urandom));
        for (int i = 0; i < 20; i++) begin
            step();
            if (dst_wr) vcs.push_back(active_vc);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL priority cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= vcs.size() || vcs[i] !== exp_pat[i]) begin
                n_fail++;
                $display("FAIL priority_pattern word %0d: got %b expected %b", i,
                         (i < vcs.size()) ? vcs[i] : 1'bx, exp_pat[i]);
            end
        end
    endtask

    task automatic test_vc1_only();
        logic [BW-1:0] sent[$];
        logic [BW-1:0] got[$];
        logic [7:0]    cnt_before;
        cnt_before = pop_cnt_vc1;
        for (int i = 0; i < 4; i++) begin
            sent.push_back(BW'($urandom));
            q1.push_back(sent[i]);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (dst_wr) got.push_back(dst_data);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL vc1_only cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (got != sent || pop_cnt_vc1 !== cnt_before + 8'd4) begin
            n_fail++;
            $display("FAIL vc1_only_order: got %0d words cnt %0d expected 4 words cnt %0d",
                     got.size(), pop_cnt_vc1, cnt_before + 8'd4);
        end
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 8; i++) q0.push_back(BW'($urandom));
        for (int i = 0; i < 8; i++) q1.push_back(BW'($urandom));
        for (int i = 0; i < 14; i++) begin
            dst_almost_full = (i >= 5 && i < 9);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL almost_full cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        dst_almost_full = 1'b0;
    endtask

    task automatic test_both_empty();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL both_empty cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) q0.push_back(BW'($urandom));
        for (int i = 0; i < 3; i++) q1.push_back(BW'($urandom));
        repeat (4) step();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL async_reset cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) q0.push_back(BW'($urandom));
            if ($urandom_range(0, 2) == 0) q1.push_back(BW'($urandom));
            dst_almost_full = ($urandom_range(0, 4) == 0);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        dst_almost_full = 1'b0;
    endtask

    task automatic test_wrap();
        q0.delete();
        q1.delete();
        pulse_reset();
        for (int i = 0; i < 260; i++) q0.push_back(BW'($urandom));
        for (int i = 0; i < 266; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (pop_cnt_vc0 !== 8'd4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected 4", pop_cnt_vc0);
        end
    endtask

    task automatic test_error();
        for (int i = 0; i < 3; i++) q0.push_back(BW'($urandom));
        dst_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) dst_full = 1'b0;
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL error cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (error_output !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: got %b expected 1", error_output);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_vc1_only();
        test_almost_full();
        test_both_empty();
        test_async_reset();
        test_random();
        test_wrap();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
